ddr_xfer_sequencer: RTL and testbench

- Sits between the command queue and the HDR-DDR mode engine.
- Accepts one transfer descriptor at a time and launches the engine with a one-cycle enable.
- Drives the engine's direction, TOC and frame-last inputs, and counts data frames as the engine completes them.
- Retries failed transfers up to a per-command limit, then returns one response word per command to the response queue.

---
 rtl/ddr_xfer_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ddr_xfer_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_xfer_sequencer.sv
// Launches the HDR-DDR engine once per descriptor, counts frames, relaunches on error up to the retry limit, and emits one response per command.
// Latency: BUS_FREE_CYC gap cycles before each launch. Backpressure: o_cmd_ready drops for the whole transfer, and the response holds until i_resp_ready.
module ddr_xfer_sequencer #(
  parameter int LEN_W        = 8,
  parameter int RETRY_W      = 2,
  parameter int BUS_FREE_CYC = 4
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_rnw,
  input  logic               i_cmd_toc,
  input  logic [LEN_W-1:0]   i_cmd_len,
  input  logic [RETRY_W-1:0] i_cmd_retry,
  output logic               o_engine_en,
  output logic               o_wr_rd_bit,
  output logic               o_toc,
  output logic               o_frmcnt_last,
  input  logic               i_frame_done,
  input  logic               i_engine_done,
  input  logic               i_error_valid,
  input  logic [1:0]         i_error_type,
  input  logic               i_abort,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [2:0]         o_resp_status,
  output logic [LEN_W-1:0]   o_resp_words
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GAP    = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam int GAP_W = (BUS_FREE_CYC > 1) ? $clog2(BUS_FREE_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BUS_FREE_CYC - 1);

  logic [2:0]         r_state;
  logic               r_cmd_rdy;
  logic               r_rnw;
  logic               r_toc;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_words;
  logic [RETRY_W-1:0] r_retry;
  logic [GAP_W-1:0]   r_gap;
  logic               r_err;
  logic [1:0]         r_etype;
  logic               r_abort;
  logic [2:0]         r_status;

  logic [LEN_W-1:0]   w_words_nxt;
  logic [LEN_W-1:0]   w_cnt_nxt;
  logic               w_err;
  logic [1:0]         w_etype;
  logic               w_abort;
  logic [2:0]         w_err_status;
  logic               w_active;

  // A frame finishing in the same cycle as engine_done is counted before evaluation.
  assign w_words_nxt = (i_frame_done && (r_words != {LEN_W{1'b1}})) ? r_words + LEN_W'(1) : r_words;
  assign w_cnt_nxt   = (i_frame_done && (r_cnt > LEN_W'(1))) ? r_cnt - LEN_W'(1) : r_cnt;
  assign w_err       = r_err | i_error_valid;
  assign w_etype     = i_error_valid ? i_error_type : r_etype;
  assign w_abort     = (r_abort | i_abort) & r_rnw;

  always_comb begin
    w_err_status = 3'b011;
    case (w_etype)
      2'b00:   w_err_status = 3'b001;
      2'b01:   w_err_status = 3'b010;
      default: w_err_status = 3'b011;
    endcase
  end

  assign w_active      = (r_state == S_GAP) || (r_state == S_LAUNCH) || (r_state == S_RUN);
  assign o_cmd_ready   = r_cmd_rdy;
  assign o_engine_en   = (r_state == S_LAUNCH);
  assign o_resp_valid  = (r_state == S_RESP);
  assign o_frmcnt_last = w_active && (r_cnt == LEN_W'(1));
  assign o_wr_rd_bit   = (r_state != S_IDLE) && r_rnw;
  // Non-final attempts must end in a restart so the bus stays owned for the retry.
  assign o_toc         = (r_state != S_IDLE) && r_toc && (r_retry == '0);
  assign o_resp_status = o_resp_valid ? r_status : 3'b000;
  assign o_resp_words  = o_resp_valid ? r_words : '0;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state   <= S_IDLE;
      r_cmd_rdy <= 1'b0;
      r_rnw     <= 1'b0;
      r_toc     <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_words   <= '0;
      r_retry   <= '0;
      r_gap     <= '0;
      r_err     <= 1'b0;
      r_etype   <= 2'b00;
      r_abort   <= 1'b0;
      r_status  <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_rdy <= 1'b1;
          if (i_cmd_valid && r_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_rnw     <= i_cmd_rnw;
            r_toc     <= i_cmd_toc;
            r_len     <= i_cmd_len;
            r_cnt     <= i_cmd_len;
            r_words   <= '0;
            r_retry   <= i_cmd_retry;
            r_gap     <= '0;
            r_err     <= 1'b0;
            r_abort   <= 1'b0;
            if (i_cmd_len == '0) begin
              r_status <= 3'b101;
              r_state  <= S_RESP;
            end else begin
              r_state  <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) r_state <= S_LAUNCH;
          else r_gap <= r_gap + GAP_W'(1);
        end
        S_LAUNCH: r_state <= S_RUN;
        S_RUN: begin
          r_words <= w_words_nxt;
          r_cnt   <= w_cnt_nxt;
          if (i_error_valid) begin
            r_err   <= 1'b1;
            r_etype <= i_error_type;
          end
          if (i_abort) r_abort <= 1'b1;
          if (i_engine_done) begin
            if (w_err && (r_retry != '0)) begin
              r_retry <= r_retry - RETRY_W'(1);
              r_cnt   <= r_len;
              r_words <= '0;
              r_err   <= 1'b0;
              r_abort <= 1'b0;
              r_gap   <= '0;
              r_state <= S_GAP;
            end else if (w_err) begin
              r_status <= w_err_status;
              r_state  <= S_RESP;
            end else if (w_abort) begin
              r_status <= 3'b100;
              r_state  <= S_RESP;
            end else begin
              r_status <= 3'b000;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_cmd_rdy <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_xfer_sequencer.sv
// Directed bench for ddr_xfer_sequencer: inputs driven and outputs sampled on the falling clock edge.
module tb_ddr_xfer_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rnw = 1'b0;
  logic       cmd_toc = 1'b0;
  logic [7:0] cmd_len = '0;
  logic [1:0] cmd_retry = '0;
  logic       engine_en, wr_rd_bit, toc, frmcnt_last;
  logic       frame_done = 1'b0, engine_done = 1'b0, error_valid = 1'b0, abort = 1'b0;
  logic [1:0] error_type = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [2:0] resp_status;
  logic [7:0] resp_words;

  int checks = 0;
  int errors = 0;

  ddr_xfer_sequencer #(.LEN_W(8), .RETRY_W(2), .BUS_FREE_CYC(4)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_rnw(cmd_rnw), .i_cmd_toc(cmd_toc), .i_cmd_len(cmd_len), .i_cmd_retry(cmd_retry),
    .o_engine_en(engine_en), .o_wr_rd_bit(wr_rd_bit), .o_toc(toc), .o_frmcnt_last(frmcnt_last),
    .i_frame_done(frame_done), .i_engine_done(engine_done),
    .i_error_valid(error_valid), .i_error_type(error_type), .i_abort(abort),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_status(resp_status), .o_resp_words(resp_words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic rnw, input logic t, input logic [7:0] len, input logic [1:0] rty);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_seen", {31'd0, cmd_ready}, 32'd1);
    cmd_rnw = rnw; cmd_toc = t; cmd_len = len; cmd_retry = rty;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Entered on the first GAP cycle; the launch must appear exactly 4 cycles later.
  task automatic wait_launch(input string tag);
    int n = 0;
    while (!engine_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, 32'd4);
  endtask

  task automatic pulse(input logic fd, input logic ed, input logic ev, input logic [1:0] et, input logic ab);
    frame_done = fd; engine_done = ed; error_valid = ev; error_type = et; abort = ab;
    @(negedge clk);
    frame_done = 1'b0; engine_done = 1'b0; error_valid = 1'b0; error_type = 2'b00; abort = 1'b0;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_dropped", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic chk_resp(input string tag, input logic [2:0] st, input logic [7:0] w);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_status"}, {29'd0, resp_status}, {29'd0, st});
    chk({tag, "_words"}, {24'd0, resp_words}, {24'd0, w});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_outputs", {27'd0, engine_en, wr_rd_bit, toc, frmcnt_last, resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Write, len 3, no retry, toc 1
    send_cmd(1'b0, 1'b1, 8'd3, 2'd0);
    chk("t1_gap_last", {31'd0, frmcnt_last}, 32'd0);
    wait_launch("t1_gap_len");
    chk("t1_toc", {31'd0, toc}, 32'd1);
    chk("t1_wr_rd", {31'd0, wr_rd_bit}, 32'd0);
    @(negedge clk);
    chk("t1_en_one_cycle", {31'd0, engine_en}, 32'd0);
    pulse(1, 0, 0, 2'b00, 0);
    chk("t1_last_after1", {31'd0, frmcnt_last}, 32'd0);
    pulse(1, 0, 0, 2'b00, 0);
    chk("t1_last_after2", {31'd0, frmcnt_last}, 32'd1);
    pulse(1, 0, 0, 2'b00, 0);
    pulse(0, 1, 0, 2'b00, 0);
    chk_resp("t1", 3'b000, 8'd3);
    chk("t1_resp_no_cmd", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_resp("t1_hold", 3'b000, 8'd3);
      chk("t1_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    ack();
    pulse(1, 1, 1, 2'b01, 1);
    chk("idle_pulses_ignored", {30'd0, resp_valid, engine_en}, 32'd0);

    // Read, len 1, toc 0
    send_cmd(1'b1, 1'b0, 8'd1, 2'd0);
    wait_launch("t2_gap_len");
    chk("t2_last_at_launch", {31'd0, frmcnt_last}, 32'd1);
    chk("t2_wr_rd", {31'd0, wr_rd_bit}, 32'd1);
    chk("t2_toc", {31'd0, toc}, 32'd0);
    @(negedge clk);
    pulse(1, 0, 0, 2'b00, 0);
    pulse(0, 1, 0, 2'b00, 0);
    chk_resp("t2", 3'b000, 8'd1);
    chk("t2_wr_rd_resp", {31'd0, wr_rd_bit}, 32'd1);
    ack();

    // Write, len 2, retry 2: CRC error twice, then clean
    send_cmd(1'b0, 1'b1, 8'd2, 2'd2);
    wait_launch("t3_gap1");
    chk("t3_toc1", {31'd0, toc}, 32'd0);
    @(negedge clk);
    pulse(1, 0, 0, 2'b00, 0);
    pulse(0, 0, 1, 2'b01, 0);
    pulse(0, 1, 0, 2'b00, 0);
    chk("t3_no_resp1", {31'd0, resp_valid}, 32'd0);
    wait_launch("t3_gap2");
    chk("t3_toc2", {31'd0, toc}, 32'd0);
    chk("t3_cnt_reload", {31'd0, frmcnt_last}, 32'd0);
    @(negedge clk);
    pulse(0, 1, 1, 2'b01, 0);
    wait_launch("t3_gap3");
    chk("t3_toc3", {31'd0, toc}, 32'd1);
    @(negedge clk);
    pulse(1, 0, 0, 2'b00, 0);
    pulse(1, 1, 0, 2'b00, 0);
    chk_resp("t3", 3'b000, 8'd2);
    ack();

    // Read, len 4, retry 1: parity error both attempts, abort also set in the second
    send_cmd(1'b1, 1'b1, 8'd4, 2'd1);
    wait_launch("t4_gap1");
    chk("t4_toc1", {31'd0, toc}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) pulse(1, 0, 0, 2'b00, 0);
    pulse(0, 0, 1, 2'b10, 0);
    pulse(0, 1, 0, 2'b00, 0);
    wait_launch("t4_gap2");
    chk("t4_toc2", {31'd0, toc}, 32'd1);
    @(negedge clk);
    pulse(1, 0, 0, 2'b00, 0);
    pulse(1, 0, 1, 2'b10, 1);
    pulse(0, 1, 0, 2'b00, 0);
    chk_resp("t4", 3'b011, 8'd2);
    ack();

    // Read, len 5, target aborts after 2 frames
    send_cmd(1'b1, 1'b1, 8'd5, 2'd1);
    wait_launch("t5_gap");
    @(negedge clk);
    pulse(1, 0, 0, 2'b00, 0);
    pulse(1, 0, 0, 2'b00, 0);
    pulse(0, 0, 0, 2'b00, 1);
    pulse(0, 1, 0, 2'b00, 0);
    chk_resp("t5", 3'b100, 8'd2);
    ack();

    // Write with abort: abort is not honoured for writes
    send_cmd(1'b0, 1'b1, 8'd1, 2'd0);
    wait_launch("t6_gap");
    @(negedge clk);
    pulse(1, 0, 0, 2'b00, 1);
    pulse(0, 1, 0, 2'b00, 0);
    chk_resp("t6", 3'b000, 8'd1);
    ack();

    // Zero length goes straight to response
    send_cmd(1'b0, 1'b1, 8'd0, 2'd0);
    chk("t7_no_launch", {31'd0, engine_en}, 32'd0);
    chk_resp("t7", 3'b101, 8'd0);
    ack();

    // Reset in the middle of RUN
    send_cmd(1'b1, 1'b1, 8'd3, 2'd0);
    wait_launch("t8_gap");
    @(negedge clk);
    pulse(1, 0, 0, 2'b00, 0);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_outputs", {26'd0, cmd_ready, engine_en, wr_rd_bit, toc, frmcnt_last, resp_valid}, 32'd0);
    pulse(0, 1, 0, 2'b00, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t8_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("t8_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
